// File: rtl/coeff_loader_if.sv
// Write-stream, status and read-port signals between the FIR control side and coeff_loader.
interface coeff_loader_if #(
  parameter int COEFF_WIDTH = 8,
  parameter int ADDR_WIDTH  = 3
);
  logic                   load_start;
  logic                   wr_valid;
  logic [COEFF_WIDTH-1:0] wr_data;
  logic                   wr_ready;
  logic                   busy;
  logic                   load_done;
  logic                   en;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [COEFF_WIDTH-1:0] coeff_out;

  modport master (
    output load_start, wr_valid, wr_data, en, addr,
    input  wr_ready, busy, load_done, coeff_out
  );

  modport slave (
    input  load_start, wr_valid, wr_data, en, addr,
    output wr_ready, busy, load_done, coeff_out
  );
endinterface

// File: rtl/coeff_loader.sv
// Writable FIR coefficient bank: burst-loaded over a valid/ready stream, read through a
// 1-cycle registered port that is frozen while a load is in progress.
module coeff_loader #(
  parameter int COEFF_WIDTH = 8,
  parameter int ADDR_WIDTH  = 3
) (
  input  logic            clock,
  input  logic            reset,
  coeff_loader_if.slave   bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [ADDR_WIDTH-1:0]  r_wptr;
  logic [COEFF_WIDTH-1:0] r_bank [DEPTH];
  logic [COEFF_WIDTH-1:0] r_coeff_p1;
  logic                   w_wr_en;
  logic                   w_last;
  logic                   w_rd_en;

  // Reset contents form a descending ramp DEPTH..1.
  function automatic logic [COEFF_WIDTH-1:0] default_coeff(input int idx);
    return COEFF_WIDTH'(DEPTH - idx);
  endfunction

  // A restart request wins over a same-cycle handshake, so that word is dropped.
  assign w_wr_en = bus.wr_valid && (r_state == S_LOAD) && !bus.load_start;
  assign w_last  = w_wr_en && (r_wptr == LAST_IDX);
  assign w_rd_en = bus.en && (r_state != S_LOAD);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.load_start) w_next = S_LOAD;
      S_LOAD: if (w_last)         w_next = S_DONE;
      S_DONE:                     w_next = S_IDLE;
      default:                    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.wr_ready  = (r_state == S_LOAD);
    bus.busy      = (r_state == S_LOAD);
    bus.load_done = (r_state == S_DONE);
  end

  // Write pointer wraps back to 0 only on the final write, which also leaves LOAD.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr <= '0;
    end else if (bus.load_start && (r_state != S_DONE)) begin
      r_wptr <= '0;
    end else if (w_wr_en) begin
      r_wptr <= r_wptr + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_bank[i] <= default_coeff(i);
      end
    end else if (w_wr_en) begin
      r_bank[r_wptr] <= bus.wr_data;
    end
  end

  // ---- read stage p1: registered bank lookup, held while loading ----
  always_ff @(posedge clock) begin
    if (reset) begin
      r_coeff_p1 <= '0;
    end else if (w_rd_en) begin
      r_coeff_p1 <= r_bank[bus.addr];
    end
  end

  assign bus.coeff_out = r_coeff_p1;
endmodule

// File: tb/tb_coeff_loader.sv
// Directed bench for coeff_loader: reset defaults, burst loads, stalls, restarts,
// read freezing during LOAD and mid-load reset.
module tb_coeff_loader;
  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  coeff_loader_if #(.COEFF_WIDTH(8), .ADDR_WIDTH(3)) bus ();

  coeff_loader #(.COEFF_WIDTH(8), .ADDR_WIDTH(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic read_chk(input string tag, input int a, input int exp);
    bus.en   = 1'b1;
    bus.addr = 3'(a);
    tick();
    check(tag, 32'(bus.coeff_out), 32'(exp));
  endtask

  task automatic write_word(input logic [7:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    tick();
    bus.wr_valid = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic rdy, input logic bsy, input logic dn);
    check({tag, "_wr_ready"},  32'(bus.wr_ready),  32'(rdy));
    check({tag, "_busy"},      32'(bus.busy),      32'(bsy));
    check({tag, "_load_done"}, 32'(bus.load_done), 32'(dn));
  endtask

  initial begin
    reset          = 1'b1;
    bus.load_start = 1'b0;
    bus.wr_valid   = 1'b0;
    bus.wr_data    = 8'h00;
    bus.en         = 1'b0;
    bus.addr       = 3'd0;
    tick();
    tick();
    check_status("rst", 1'b0, 1'b0, 1'b0);
    check("rst_coeff_out", 32'(bus.coeff_out), 32'h0);
    reset = 1'b0;

    // 1: default ramp 8..1
    for (int a = 0; a < 8; a++) read_chk("t1_default", a, 8 - a);
    bus.en = 1'b0;
    tick();
    check("t1_en0_hold", 32'(bus.coeff_out), 32'h1);

    // 2: back-to-back burst 0x11..0x18
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    check_status("t2_load", 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      write_word(8'(8'h11 + k));
      if (k < 7) check("t2_no_early_done", 32'(bus.load_done), 32'h0);
    end
    check_status("t2_done", 1'b0, 1'b0, 1'b1);
    tick();
    check_status("t2_idle", 1'b0, 1'b0, 1'b0);
    for (int a = 0; a < 8; a++) read_chk("t2_bank", a, 8'h11 + a);

    // 3+4: load with a stall gap while en=1/addr=5 is held
    read_chk("t4_pre", 5, 8'h16);
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    write_word(8'h31);
    write_word(8'h32);
    for (int g = 0; g < 3; g++) begin
      tick();
      check("t3_gap_busy", 32'(bus.busy), 32'h1);
      check("t4_gap_hold", 32'(bus.coeff_out), 32'h16);
    end
    for (int k = 2; k < 8; k++) begin
      write_word(8'(8'h31 + k));
      if (k < 7) check("t3_no_early_done", 32'(bus.load_done), 32'h0);
    end
    check("t3_done", 32'(bus.load_done), 32'h1);
    check("t4_hold_at_done", 32'(bus.coeff_out), 32'h16);
    tick();
    check("t4_done_read", 32'(bus.coeff_out), 32'h36);
    check("t3_single_pulse", 32'(bus.load_done), 32'h0);
    for (int a = 0; a < 8; a++) read_chk("t3_bank", a, 8'h31 + a);

    // 5: restart after 4 writes; same-cycle write is dropped
    bus.en = 1'b0;
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    for (int k = 0; k < 4; k++) write_word(8'(8'h51 + k));
    bus.load_start = 1'b1;
    bus.wr_valid   = 1'b1;
    bus.wr_data    = 8'hEE;
    tick();
    bus.load_start = 1'b0;
    bus.wr_valid   = 1'b0;
    check_status("t5_restart", 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) write_word(8'(8'hA0 + k));
    check("t5_done", 32'(bus.load_done), 32'h1);
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    check_status("t5_start_in_done_ignored", 1'b0, 1'b0, 1'b0);
    for (int a = 0; a < 8; a++) read_chk("t5_bank", a, 8'hA0 + a);

    // 6: reset in the middle of a load
    bus.en = 1'b0;
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    for (int k = 0; k < 3; k++) write_word(8'hFF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_status("t6_rst", 1'b0, 1'b0, 1'b0);
    check("t6_rst_coeff_out", 32'(bus.coeff_out), 32'h0);
    for (int a = 0; a < 8; a++) read_chk("t6_default", a, 8 - a);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
